// File: rtl/joystick_conditioner.sv
// Joystick/button input conditioning: synchronise, debounce, and turn the
// debounced levels into one-cycle menu commands with hold-to-repeat on up/down.

module jc_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // The counter only runs while the synchronised input disagrees with the
    // debounced level, so any agreement restarts the stability window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            count  <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end
endmodule

module jc_repeat #(
    parameter int DELAY_CYCLES  = 12500000,
    parameter int PERIOD_CYCLES = 2500000
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic conflict,
    output logic pulse
);
    localparam int LONGEST = (DELAY_CYCLES > PERIOD_CYCLES) ? DELAY_CYCLES : PERIOD_CYCLES;
    localparam int CW = $clog2(LONGEST + 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          active_prev;

    // Losing 'active' is checked before the terminal count, so a pulse due on
    // the cycle the release is seen is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            pulse       <= 1'b0;
            active_prev <= 1'b0;
        end else begin
            active_prev <= active;
            pulse       <= 1'b0;
            if (conflict) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (active && !active_prev) begin
                            pulse <= 1'b1;
                            count <= '0;
                            state <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (!active) begin
                            state <= IDLE;
                            count <= '0;
                        end else if (count == DELAY_LAST) begin
                            pulse <= 1'b1;
                            count <= '0;
                            state <= REPEAT;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    REPEAT: begin
                        if (!active) begin
                            state <= IDLE;
                            count <= '0;
                        end else if (count == PERIOD_LAST) begin
                            pulse <= 1'b1;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module joystick_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 250000,
    parameter int REPEAT_DELAY_CYCLES  = 12500000,
    parameter int REPEAT_PERIOD_CYCLES = 2500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    input  logic raw_select,
    output logic control_up,
    output logic control_down,
    output logic control_select,
    output logic held_up,
    output logic held_down
);
    logic db_up;
    logic db_down;
    logic db_select;
    logic up_eff;
    logic down_eff;
    logic both_held;
    logic select_prev;

    jc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock (clock),
        .reset (reset),
        .raw   (raw_up),
        .level (db_up)
    );

    jc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock (clock),
        .reset (reset),
        .raw   (raw_down),
        .level (db_down)
    );

    jc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .clock (clock),
        .reset (reset),
        .raw   (raw_select),
        .level (db_select)
    );

    // Up and down together cancel each other; neither direction is acted on.
    assign both_held = db_up & db_down;
    assign up_eff    = db_up & ~db_down;
    assign down_eff  = db_down & ~db_up;
    assign held_up   = up_eff;
    assign held_down = down_eff;

    jc_repeat #(
        .DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_rep_up (
        .clock    (clock),
        .reset    (reset),
        .active   (up_eff),
        .conflict (both_held),
        .pulse    (control_up)
    );

    jc_repeat #(
        .DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_rep_down (
        .clock    (clock),
        .reset    (reset),
        .active   (down_eff),
        .conflict (both_held),
        .pulse    (control_down)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            select_prev    <= 1'b0;
            control_select <= 1'b0;
        end else begin
            select_prev    <= db_select;
            control_select <= db_select & ~select_prev;
        end
    end
endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with short debounce/repeat timings;
// expected outputs are hand-computed per cycle after each rising edge.

module tb_joystick_conditioner;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    // Output vector order: {control_up, control_down, control_select, held_up, held_down}
    localparam logic [4:0] Z     = 5'b00000;
    localparam logic [4:0] HU    = 5'b00010;
    localparam logic [4:0] HD    = 5'b00001;
    localparam logic [4:0] CU_HU = 5'b10010;
    localparam logic [4:0] CD_HD = 5'b01001;
    localparam logic [4:0] CS    = 5'b00100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic raw_up = 1'b0;
    logic raw_down = 1'b0;
    logic raw_select = 1'b0;
    logic control_up;
    logic control_down;
    logic control_select;
    logic held_up;
    logic held_down;

    typedef struct {
        string      tag;
        logic       up;
        logic       down;
        logic       sel;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    joystick_conditioner #(
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .raw_up         (raw_up),
        .raw_down       (raw_down),
        .raw_select     (raw_select),
        .control_up     (control_up),
        .control_down   (control_down),
        .control_select (control_select),
        .held_up        (held_up),
        .held_down      (held_down)
    );

    always #5 clock = ~clock;

    function automatic void add(string tag, logic u, logic d, logic s, int n, logic [4:0] e);
        vec_t v;
        v.tag  = tag;
        v.up   = u;
        v.down = d;
        v.sel  = s;
        v.n    = n;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string tag, int cyc, logic [4:0] exp);
        logic [4:0] got;
        got = {control_up, control_down, control_select, held_up, held_down};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: outputs %b, expected %b (cu cd cs hu hd)", tag, cyc, got, exp);
        end
    endtask

    initial begin
        string      prev_tag;
        int         cyc;
        logic [4:0] e;

        // Clean press and hold of up for 40 cycles
        add("hold", 1, 0, 0, 5, Z);
        add("hold", 1, 0, 0, 1, HU);
        add("hold", 1, 0, 0, 1, CU_HU);
        add("hold", 1, 0, 0, 9, HU);
        add("hold", 1, 0, 0, 1, CU_HU);
        for (int p = 20; p <= 38; p += 3) begin
            add("hold", 1, 0, 0, 2, HU);
            add("hold", 1, 0, 0, 1, CU_HU);
        end
        add("hold", 1, 0, 0, 2, HU);
        add("hold", 0, 0, 0, 1, CU_HU);
        add("hold", 0, 0, 0, 2, HU);
        add("hold", 0, 0, 0, 1, CU_HU);
        add("hold", 0, 0, 0, 1, HU);
        add("hold", 0, 0, 0, 5, Z);
        // Three-cycle glitch on down
        add("glitch", 0, 1, 0, 3, Z);
        add("glitch", 0, 0, 0, 8, Z);
        // Select held 30 cycles
        add("select", 0, 0, 1, 6, Z);
        add("select", 0, 0, 1, 1, CS);
        add("select", 0, 0, 1, 23, Z);
        add("select", 0, 0, 0, 10, Z);
        // Short down hold: release lands exactly on the would-be delay pulse
        add("short", 0, 1, 0, 5, Z);
        add("short", 0, 1, 0, 1, HD);
        add("short", 0, 1, 0, 1, CD_HD);
        add("short", 0, 1, 0, 3, HD);
        add("short", 0, 0, 0, 5, HD);
        add("short", 0, 0, 0, 10, Z);
        // Up held, down joins then drops, then up released
        add("conflict", 1, 0, 0, 5, Z);
        add("conflict", 1, 0, 0, 1, HU);
        add("conflict", 1, 0, 0, 1, CU_HU);
        add("conflict", 1, 0, 0, 1, HU);
        add("conflict", 1, 1, 0, 5, HU);
        add("conflict", 1, 1, 0, 17, Z);
        add("conflict", 1, 0, 0, 5, Z);
        add("conflict", 1, 0, 0, 1, HU);
        add("conflict", 1, 0, 0, 1, CU_HU);
        add("conflict", 1, 0, 0, 3, HU);
        add("conflict", 0, 0, 0, 5, HU);
        add("conflict", 0, 0, 0, 7, Z);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 0, Z);
        reset = 1'b1;

        prev_tag = "";
        cyc = 0;
        foreach (vecs[i]) begin
            if (vecs[i].tag != prev_tag) begin
                prev_tag = vecs[i].tag;
                cyc = 0;
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                raw_up     = vecs[i].up;
                raw_down   = vecs[i].down;
                raw_select = vecs[i].sel;
                @(posedge clock);
                #1;
                cyc++;
                check(vecs[i].tag, cyc, vecs[i].exp);
            end
        end

        // Reset asserted mid-REPEAT, right after a pulse
        raw_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            e = Z;
            if (k >= 6) e = HU;
            if (k == 7 || k == 17 || k == 20) e = CU_HU;
            check("pre_reset", k, e);
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, Z);
        @(posedge clock);
        #1;
        check("in_reset", 0, Z);
        reset = 1'b1;

        // Restart with up still held, then release at cycle 25
        for (int k = 1; k <= 34; k++) begin
            raw_up = (k <= 24);
            @(posedge clock);
            #1;
            e = Z;
            if (k >= 6 && k <= 29) e = HU;
            if (k == 7 || k == 17 || k == 20 || k == 23 || k == 26 || k == 29) e = CU_HU;
            check("post_reset", k, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
